cacheline_mem_arbiter: RTL and testbench
========================================

Name: cacheline_mem_arbiter

Overview:
- Shares one 256-bit cacheline memory port between two cacheline clients: client 0 (I-cache) and client 1 (D-cache).
- Allows one outstanding transaction at a time and uses round-robin grant on contention.
- Drives the memory side from registers, so address, data and control stay stable until the memory responds.
- Sits between the cache pair and the cacheline memory/adaptor.

Parameters:
- ADDR_WIDTH, 32, byte address width; the low 5 bits are zero for line-aligned requests.
- LINE_WIDTH, 256, cacheline data width.
- TIMEOUT, 1024, maximum cycles in BUSY before the sticky error flag sets.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- c0_read / c1_read  in  1  client line-read request; held high until that client's resp
- c0_write / c1_write  in  1  client line-write request; held high until that client's resp
- c0_addr / c1_addr  in  ADDR_WIDTH  client line address
- c0_wdata / c1_wdata  in  LINE_WIDTH  client write line
- c0_rdata / c1_rdata  out  LINE_WIDTH  read line; valid only while the matching resp is high
- c0_resp / c1_resp  out  1  one-cycle completion pulse
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion pulse
- busy  out  1  a transaction is in flight
- error  out  1  sticky protocol/timeout error

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - mem_read, mem_write, c*_resp, busy and error are 0.
  - mem_addr and mem_wdata are 0.
  - last_grant is 1, so client 0 wins the first tie.
  - The timeout counter is 0.
- States: IDLE, BUSY. A 1-bit owner register records the granted client.
- IDLE, per cycle:
  - req_i = ci_read | ci_write.
  - No request: stay in IDLE.
  - One client requesting: grant it.
  - Both requesting: grant !last_grant.
  - On grant, at the next edge:
    - Latch op, addr and wdata into the memory-side registers.
    - Assert mem_read or mem_write.
    - Set owner and last_grant.
    - Enter BUSY.
  - A request therefore reaches memory 1 cycle after the client asserts it.
- BUSY:
  - Memory outputs hold their latched values.
  - Client inputs are ignored, apart from the protocol checks below.
  - While mem_resp=1, the resp for the owner is combinationally high (cO_resp=1). The other client's resp stays 0.
  - On that same mem_resp cycle, cO_rdata = mem_rdata.
  - At the edge where mem_resp is sampled high: clear mem_read/mem_write and return to IDLE.
  - This guarantees at least one idle cycle on memory between transactions.
- Earliest regrant: the cycle after returning to IDLE. A client that keeps its request high past resp is treated as a new request.
- Latency: client request to memory strobe is 1 cycle. Memory resp to client resp is 0 cycles (combinational forward).
- c*_rdata when its resp is 0: drive 0.
- busy = (state == BUSY).
- Fairness: with both clients continuously requesting, grants strictly alternate 0,1,0,1.
- Error (sticky until rst), set at the edge when any of these is sampled:
  - A client asserts read and write together. The grant still proceeds, with read taking priority.
  - A requesting client's read, write or addr is X.
  - A requesting client's addr[4:0] is not 0.
  - mem_resp is high while in IDLE. The pulse is ignored.
  - The timeout counter reaches TIMEOUT while in BUSY. The transaction stays pending; no abort.
- Timeout counter: clears on entering BUSY and saturates at TIMEOUT.
- Reset mid-transaction: everything returns to the reset state immediately. A late mem_resp arriving in IDLE after reset-deassert sets error. Memory is on the same rst, so this case is only reachable in isolated tests.

Decomposition:
- Shared package cache_mem_pkg holds:
  - arb_state_t {IDLE, BUSY}
  - mem_op_t {OP_READ, OP_WRITE}
  - localparams LINE_WIDTH=256, ADDR_WIDTH=32, LINE_OFFSET_BITS=5
- Natural sub-module rr_arbiter2: a 2-way round-robin grant with request, grant and update enable, holding the last_grant register.
- The FSM, the latch registers and the response demux stay in the top module.

Test Plan:
- Single read: c0_read, addr 0x0000_1000; memory resp at +10 with data 0xA5..A5 → mem_read high from cycle+1, addr stable; c0_resp 1 cycle with the data; c1_resp=0; mem_read low the cycle after resp.
- Single write: c1_write, addr 0x0000_2020, wdata 0x1234..; resp after 10 → mem_wdata matches; c1_resp pulses once; a read-back of 0x2020 via c0 returns 0x1234...
- Contention: both clients read on the same cycle right after reset → client 0 is served first, then client 1 with ≥1 idle memory cycle between; 4 back-to-back rounds give grants 0,1,0,1.
- Stability: a client changes its addr mid-BUSY → mem_addr unchanged; error stays 0.
- Errors: c0 issues read+write with addr 0x0000_1004 → error=1 after the edge and stays set. A separate test with TIMEOUT=16 and memory never responding → error after 16 BUSY cycles.
- Reset mid-read: assert rst in BUSY → mem_read=0, busy=0, resp=0 immediately; after deassert a new c1 request is granted normally.

Source files
------------

// File: rtl/cache_mem_pkg.sv
`default_nettype none
// ============================================================================
// cache_mem_pkg : shared types and line geometry for the cacheline arbiter
// Revision      : 1.0
// ============================================================================
package cache_mem_pkg;

  localparam int LINE_WIDTH       = 256;
  localparam int ADDR_WIDTH       = 32;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  function automatic logic line_misaligned(input logic [LINE_OFFSET_BITS-1:0] low_bits);
    return |low_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-way round-robin grant; remembers the most recent winner
// Revision    : 1.0
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic r_last_grant;

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~r_last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

  // Resets to 1 so that client 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (update && grant_valid) begin
      r_last_grant <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cacheline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// cacheline_mem_arbiter : shares one cacheline memory port between I/D caches
// Revision              : 1.0
// ============================================================================
module cacheline_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = cache_mem_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH = cache_mem_pkg::LINE_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c0_read,
  input  logic                  c0_write,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [LINE_WIDTH-1:0] c0_wdata,
  output logic [LINE_WIDTH-1:0] c0_rdata,
  output logic                  c0_resp,
  input  logic                  c1_read,
  input  logic                  c1_write,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [LINE_WIDTH-1:0] c1_wdata,
  output logic [LINE_WIDTH-1:0] c1_rdata,
  output logic                  c1_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  busy,
  output logic                  error
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic                  r_owner;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_error;

  logic [1:0]            w_req;
  logic                  w_grant_valid;
  logic                  w_grant_idx;
  logic                  w_grant;
  logic                  w_sel_read;
  mem_op_t               w_sel_op;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LINE_WIDTH-1:0] w_sel_wdata;
  logic                  w_resp_live;

  logic                  w_err_rw;
  logic                  w_err_align;
  logic                  w_err_x;
  logic                  w_err_idle_resp;
  logic                  w_err_tmo;

  assign w_req   = {c1_read | c1_write, c0_read | c0_write};
  assign w_grant = (r_state == IDLE) && w_grant_valid;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (w_req),
    .update      (w_grant),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // Read wins when a client illegally raises both strobes.
  assign w_sel_read  = w_grant_idx ? c1_read  : c0_read;
  assign w_sel_op    = w_sel_read ? OP_READ : OP_WRITE;
  assign w_sel_addr  = w_grant_idx ? c1_addr  : c0_addr;
  assign w_sel_wdata = w_grant_idx ? c1_wdata : c0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    w_resp_live  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (mem_resp) begin
          w_resp_live  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Memory side is fully registered so it holds steady until mem_resp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_owner   <= 1'b0;
      r_tmo     <= '0;
    end else if (w_grant) begin
      mem_read  <= (w_sel_op == OP_READ);
      mem_write <= (w_sel_op == OP_WRITE);
      mem_addr  <= w_sel_addr;
      mem_wdata <= w_sel_wdata;
      r_owner   <= w_grant_idx;
      r_tmo     <= '0;
    end else if (r_state == BUSY) begin
      if (mem_resp) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (r_tmo != TMO_MAX) begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  assign c0_resp  = w_resp_live & ~r_owner;
  assign c1_resp  = w_resp_live &  r_owner;
  assign c0_rdata = c0_resp ? mem_rdata : '0;
  assign c1_rdata = c1_resp ? mem_rdata : '0;

  assign w_err_rw    = (c0_read & c0_write) | (c1_read & c1_write);
  assign w_err_align = (w_req[0] & line_misaligned(c0_addr[LINE_OFFSET_BITS-1:0]))
                     | (w_req[1] & line_misaligned(c1_addr[LINE_OFFSET_BITS-1:0]));
  // Unknown-value checks only fire in 4-state simulation; in silicon they are 0.
  assign w_err_x     = $isunknown({c0_read, c0_write, c1_read, c1_write})
                     | (w_req[0] & $isunknown(c0_addr))
                     | (w_req[1] & $isunknown(c1_addr));
  assign w_err_idle_resp = (r_state == IDLE) & mem_resp;
  assign w_err_tmo       = (r_state == BUSY) & (r_tmo >= TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (w_err_rw | w_err_align | w_err_x | w_err_idle_resp | w_err_tmo) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_cacheline_mem_arbiter : self-checking bench with a transaction-level model
// Revision                 : 1.0
// ============================================================================
module tb_cacheline_mem_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_read, c0_write, c1_read, c1_write;
  logic [AW-1:0] c0_addr, c1_addr, mem_addr;
  logic [LW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, mem_wdata, mem_rdata;
  logic          c0_resp, c1_resp, mem_read, mem_write, mem_resp, busy, error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LW-1:0] store   [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  bit            mem_en  = 1'b1;
  int            mem_lat = 4;
  bit            pend    = 1'b0;
  int            lat_cnt = 0;
  bit            ref_last;

  cacheline_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .c0_read(c0_read), .c0_write(c0_write), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_resp(c0_resp),
    .c1_read(c1_read), .c1_write(c1_write), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_resp(c1_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory responder: answers a strobe after mem_lat cycles.
  always @(posedge clk) begin
    #1;
    if (mem_en) mem_resp = 1'b0;
    mem_rdata = {8{$urandom}};
    if (rst) begin
      pend = 1'b0;
    end else if (mem_en && (mem_read || mem_write)) begin
      if (!pend) begin
        pend    = 1'b1;
        lat_cnt = mem_lat;
      end
      if (lat_cnt == 0) begin
        if (mem_write) store[mem_addr] = mem_wdata;
        else mem_rdata = store.exists(mem_addr) ? store[mem_addr] : dflt(mem_addr);
        mem_resp = 1'b1;
        pend     = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
  end

  task automatic drive(input bit c, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [LW-1:0] d);
    if (c == 1'b0) begin
      c0_read = rd; c0_write = wr; c0_addr = a; c0_wdata = d;
    end else begin
      c1_read = rd; c1_write = wr; c1_addr = a; c1_wdata = d;
    end
  endtask

  task automatic drop(input bit c);
    @(posedge clk);
    #1;
    drive(c, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_any(input int budget, output bit got, output bit who,
                          output logic [LW-1:0] data, output bit both);
    got = 1'b0; who = 1'b0; data = '0; both = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (c0_resp || c1_resp) begin
        got  = 1'b1;
        who  = c1_resp;
        data = c1_resp ? c1_rdata : c0_rdata;
        both = c0_resp && c1_resp;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    mem_resp = 1'b0;
    mem_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    ref_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got %b%b want 00", mem_read, mem_write); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_checks++; if (c0_resp !== 1'b0 || c1_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b%b want 00", c1_resp, c0_resp); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_checks++; if (c0_rdata !== '0 || c1_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h / %h want 0", c0_rdata, c1_rdata); end
  endtask

  task automatic test_single_read();
    bit got, who, both;
    logic [LW-1:0] data;
    store[32'h1000]   = {32{8'hA5}};
    ref_mem[32'h1000] = {32{8'hA5}};
    mem_lat = 10;
    drive(1'b0, 1'b1, 1'b0, 32'h1000, '0);
    @(negedge clk);
    n_checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rd_strobe: got rd=%b wr=%b want 1 0", mem_read, mem_write); end
    n_checks++; if (mem_addr !== 32'h1000) begin n_fail++; $display("FAIL rd_addr: got %h want 00001000", mem_addr); end
    n_checks++; if (c0_rdata !== '0) begin n_fail++; $display("FAIL rd_rdata_gated: got %h want 0", c0_rdata); end
    wait_any(40, got, who, data, both);
    n_checks++; if (!got || who !== 1'b0 || both) begin n_fail++; $display("FAIL rd_resp: got=%b who=%b both=%b want 1 0 0", got, who, both); end
    n_checks++; if (data !== ref_rd(32'h1000)) begin n_fail++; $display("FAIL rd_data: got %h want %h", data, ref_rd(32'h1000)); end
    n_checks++; if (mem_addr !== 32'h1000) begin n_fail++; $display("FAIL rd_addr_hold: got %h want 00001000", mem_addr); end
    drop(1'b0);
    @(negedge clk);
    n_checks++; if (mem_read !== 1'b0 || c0_resp !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_after: got rd=%b resp=%b busy=%b want 0 0 0", mem_read, c0_resp, busy); end
  endtask

  task automatic test_single_write();
    bit got, who, both;
    logic [LW-1:0] data;
    logic [LW-1:0] wd;
    wd = {8{32'h1234_5678}};
    mem_lat = 10;
    drive(1'b1, 1'b0, 1'b1, 32'h2020, wd);
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL wr_strobe: got rd=%b wr=%b want 0 1", mem_read, mem_write); end
    n_checks++; if (mem_wdata !== wd || mem_addr !== 32'h2020) begin n_fail++; $display("FAIL wr_bus: got %h @%h want %h @00002020", mem_wdata, mem_addr, wd); end
    wait_any(40, got, who, data, both);
    n_checks++; if (!got || who !== 1'b1) begin n_fail++; $display("FAIL wr_resp: got=%b who=%b want 1 1", got, who); end
    ref_mem[32'h2020] = wd;
    drop(1'b1);
    @(negedge clk);
    n_checks++; if (c1_resp !== 1'b0) begin n_fail++; $display("FAIL wr_resp_pulse: got %b want 0", c1_resp); end
    mem_lat = 3;
    drive(1'b0, 1'b1, 1'b0, 32'h2020, '0);
    wait_any(40, got, who, data, both);
    n_checks++; if (!got || who !== 1'b0 || data !== ref_rd(32'h2020)) begin n_fail++; $display("FAIL wr_readback: got %h who=%b want %h", data, who, ref_rd(32'h2020)); end
    drop(1'b0);
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit got, who, idle, exp_who;
    logic [LW-1:0] data;
    do_reset();
    mem_lat = 3;
    drive(1'b0, 1'b1, 1'b0, 32'h1000, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h2020, '0);
    exp_who = ~ref_last;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0; who = 1'b0; idle = 1'b0; data = '0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (!mem_read && !mem_write) idle = 1'b1;
        if (c0_resp || c1_resp) begin
          got  = 1'b1;
          who  = c1_resp;
          data = c1_resp ? c1_rdata : c0_rdata;
        end
      end
      n_checks++; if (!got || who !== exp_who) begin n_fail++; $display("FAIL rr_order[%0d]: got=%b who=%b want who=%b", k, got, who, exp_who); end
      if (k > 0) begin
        n_checks++; if (!idle) begin n_fail++; $display("FAIL rr_idle_gap[%0d]: got no idle cycle want >=1", k); end
      end
      n_checks++; if (data !== ref_rd(who ? 32'h2020 : 32'h1000)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, data, ref_rd(who ? 32'h2020 : 32'h1000)); end
      if (!got) break;
      ref_last = who;
      exp_who  = ~who;
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_stability();
    bit got, who, both;
    logic [LW-1:0] data;
    mem_lat = 8;
    drive(1'b0, 1'b1, 1'b0, 32'h3000, '0);
    repeat (2) @(negedge clk);
    c0_addr = 32'h3040;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (mem_addr !== 32'h3000) begin n_fail++; $display("FAIL stab_addr[%0d]: got %h want 00003000", i, mem_addr); end
    end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL stab_error: got %b want 0", error); end
    wait_any(40, got, who, data, both);
    n_checks++; if (!got || data !== ref_rd(32'h3000)) begin n_fail++; $display("FAIL stab_data: got %h want %h", data, ref_rd(32'h3000)); end
    drop(1'b0);
    @(negedge clk);
  endtask

  task automatic test_random();
    bit got, who, both, ok;
    logic [LW-1:0] data;
    logic [1:0] mask;
    bit rd [2];
    logic [AW-1:0] addr [2];
    logic [LW-1:0] wd [2];
    bit order [2];
    int n;
    ok = 1'b1;
    for (int r = 0; r < 30 && ok; r++) begin
      mem_lat = $urandom_range(0, 6);
      mask    = 2'($urandom_range(1, 3));
      for (int c = 0; c < 2; c++) begin
        rd[c]   = 1'($urandom_range(0, 1));
        addr[c] = 32'h4000 + 32'($urandom_range(0, 7)) * 32;
        wd[c]   = {8{$urandom}};
        if (mask[c]) drive(1'(c), rd[c], ~rd[c], addr[c], wd[c]);
      end
      if (mask == 2'b11) begin
        order[0] = ~ref_last; order[1] = ref_last; n = 2;
      end else begin
        order[0] = mask[1]; order[1] = 1'b0; n = 1;
      end
      for (int j = 0; j < n; j++) begin
        wait_any(60, got, who, data, both);
        n_checks++; if (!got || who !== order[j] || both) begin n_fail++; $display("FAIL rand_order[%0d.%0d]: got=%b who=%b both=%b want who=%b", r, j, got, who, both, order[j]); end
        if (!got) begin
          ok = 1'b0;
          break;
        end
        if (rd[who]) begin
          n_checks++; if (data !== ref_rd(addr[who])) begin n_fail++; $display("FAIL rand_data[%0d.%0d]: got %h want %h", r, j, data, ref_rd(addr[who])); end
        end else begin
          ref_mem[addr[who]] = wd[who];
        end
        ref_last = who;
        drop(who);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    if (!ok) do_reset();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got, who, both;
    logic [LW-1:0] data;
    mem_lat = 10;
    drive(1'b1, 1'b1, 1'b0, 32'h5000, '0);
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_read !== 1'b0 || busy !== 1'b0 || c1_resp !== 1'b0) begin n_fail++; $display("FAIL mid_async: got rd=%b busy=%b resp=%b want 0 0 0", mem_read, busy, c1_resp); end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    ref_last = 1'b1;
    @(negedge clk);
    mem_lat = 2;
    drive(1'b1, 1'b1, 1'b0, 32'h5020, '0);
    wait_any(40, got, who, data, both);
    n_checks++; if (!got || who !== 1'b1 || data !== ref_rd(32'h5020)) begin n_fail++; $display("FAIL mid_regrant: got=%b who=%b data=%h want 1 1 %h", got, who, data, ref_rd(32'h5020)); end
    drop(1'b1);
    @(negedge clk);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL mid_error: got %b want 0", error); end
  endtask

  task automatic test_err_protocol();
    bit got, who, both;
    logic [LW-1:0] data;
    bit rd_t [3] = '{1'b1, 1'b1, 1'b0};
    bit wr_t [3] = '{1'b1, 1'b1, 1'b1};
    logic [AW-1:0] a_t [3] = '{32'h1004, 32'h1000, 32'h2024};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      mem_lat = 2;
      drive(1'(t == 2), rd_t[t], wr_t[t], a_t[t], '0);
      @(negedge clk);
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_set[%0d]: got %b want 1", t, error); end
      n_checks++; if (mem_read !== rd_t[t] || mem_write !== !rd_t[t]) begin n_fail++; $display("FAIL err_op[%0d]: got rd=%b wr=%b want %b %b", t, mem_read, mem_write, rd_t[t], !rd_t[t]); end
      wait_any(40, got, who, data, both);
      drop(who);
      repeat (3) @(negedge clk);
      n_checks++; if (error !== 1'b1 || !got) begin n_fail++; $display("FAIL err_sticky[%0d]: got err=%b resp=%b want 1 1", t, error, got); end
    end
    do_reset();
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", error); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_en   = 1'b0;
    mem_resp = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0100, '0);
    @(negedge clk);
    repeat (13) @(negedge clk);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", error); end
    repeat (5) @(negedge clk);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", error); end
    n_checks++; if (busy !== 1'b1 || mem_read !== 1'b1) begin n_fail++; $display("FAIL tmo_pending: got busy=%b rd=%b want 1 1", busy, mem_read); end
    do_reset();
  endtask

  task automatic test_idle_resp();
    do_reset();
    mem_en   = 1'b0;
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL idle_resp_err: got %b want 1", error); end
    n_checks++; if (busy !== 1'b0 || c0_resp !== 1'b0 || c1_resp !== 1'b0) begin n_fail++; $display("FAIL idle_resp_ignored: got busy=%b resp=%b%b want 0 00", busy, c1_resp, c0_resp); end
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    c0_read = 1'b0; c0_write = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_read = 1'b0; c1_write = 1'b0; c1_addr = '0; c1_wdata = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    ref_last  = 1'b1;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_stability();
    test_random();
    test_reset_mid();
    test_err_protocol();
    test_timeout();
    test_idle_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
